// File: rtl/fifo_pkg.sv
// Shared sizing for the RAM-backed FIFO: word width, depth, address width,
// pointer type and almost-full/almost-empty threshold defaults.
package fifo_pkg;

    localparam int WIDTH_DEF    = 8;
    localparam int DEPTH_DEF    = 64;
    localparam int ADDR_BUS_DEF = $clog2(DEPTH_DEF);
    localparam int AF_MARGIN    = 4;
    localparam int AE_LEVEL_DEF = 4;

    // One extra MSB acts as the wrap bit that tells full from empty.
    typedef logic [ADDR_BUS_DEF:0] ptr_t;

endpackage

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller driving a dual-port RAM: port 1 writes, port 2 reads every
// cycle; the RAM's registered read data is passed straight to the consumer.
module ram_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int ADDR_BUS = $clog2(DEPTH),
    parameter int AF_LEVEL = DEPTH - AF_MARGIN,
    parameter int AE_LEVEL = AE_LEVEL_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic                rd_en,
    output logic [WIDTH-1:0]    rd_data,
    output logic                rd_valid,
    output logic                full,
    output logic                empty,
    output logic                almost_full,
    output logic                almost_empty,
    output logic [ADDR_BUS:0]   count,
    output logic                overflow,
    output logic                underflow,
    output logic                ram_rst_n,
    output logic                ram_we_1,
    output logic [ADDR_BUS-1:0] ram_addr_1,
    output logic [WIDTH-1:0]    ram_din_1,
    output logic                ram_we_2,
    output logic [ADDR_BUS-1:0] ram_addr_2,
    output logic [WIDTH-1:0]    ram_din_2,
    input  logic [WIDTH-1:0]    ram_dout_2
);

    localparam int                CNT_W = ADDR_BUS + 1;
    localparam logic [ADDR_BUS:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [ADDR_BUS:0] AF_C    = CNT_W'(AF_LEVEL);
    localparam logic [ADDR_BUS:0] AE_C    = CNT_W'(AE_LEVEL);

    logic [ADDR_BUS:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_BUS:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_BUS:0] count_q, count_d;
    logic              full_q, empty_q, af_q, ae_q;
    logic              rd_valid_q;
    logic              ovf_q, ovf_d, udf_q, udf_d;
    logic              push_ok, pop_ok;

    // A push into a full FIFO is still legal when a pop frees the slot in
    // the same cycle; the RAM's read-before-write returns the old word.
    always_comb begin
        pop_ok   = rd_en & ~empty_q;
        push_ok  = wr_en & (~full_q | pop_ok);
        wr_ptr_d = wr_ptr_q + CNT_W'(push_ok);
        rd_ptr_d = rd_ptr_q + CNT_W'(pop_ok);
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        ovf_d    = ovf_q | (wr_en & ~push_ok);
        udf_d    = udf_q | (rd_en & ~pop_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            af_q       <= 1'b0;
            ae_q       <= 1'b1;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= (count_d == DEPTH_C);
            empty_q    <= (count_d == '0);
            af_q       <= (count_d >= AF_C);
            ae_q       <= (count_d <= AE_C);
            rd_valid_q <= pop_ok;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    assign count        = count_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;
    assign rd_valid     = rd_valid_q;
    assign rd_data      = ram_dout_2;

    // RAM reset follows rst directly so storage clears in the same cycles.
    assign ram_rst_n  = ~rst;
    assign ram_we_1   = push_ok;
    assign ram_addr_1 = wr_ptr_q[ADDR_BUS-1:0];
    assign ram_din_1  = wr_data;
    assign ram_we_2   = 1'b0;
    assign ram_addr_2 = rd_ptr_q[ADDR_BUS-1:0];
    assign ram_din_2  = '0;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl with a behavioural 64x8 read-before-write RAM and
// a queue-based reference model of the FIFO.
module tb_ram_fifo_ctrl;

    localparam int W = 8;
    localparam int D = 64;
    localparam int A = 6;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wr_en = 1'b0, rd_en = 1'b0;
    logic [W-1:0] wr_data = '0;
    logic [W-1:0] rd_data;
    logic         rd_valid, full, empty, almost_full, almost_empty;
    logic [A:0]   count;
    logic         overflow, underflow, ram_rst_n;
    logic         ram_we_1, ram_we_2;
    logic [A-1:0] ram_addr_1, ram_addr_2;
    logic [W-1:0] ram_din_1, ram_din_2, ram_dout_2;

    ram_fifo_ctrl dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow), .ram_rst_n(ram_rst_n),
        .ram_we_1(ram_we_1), .ram_addr_1(ram_addr_1), .ram_din_1(ram_din_1),
        .ram_we_2(ram_we_2), .ram_addr_2(ram_addr_2), .ram_din_2(ram_din_2),
        .ram_dout_2(ram_dout_2)
    );

    always #5 clk = ~clk;

    // Dual-port RAM: both ports on clk, registered read, read before write.
    logic [W-1:0] mem [D];
    initial ram_dout_2 = '0;
    always @(posedge clk) begin
        if (!ram_rst_n) ram_dout_2 <= '0;
        else begin
            if (ram_we_1) mem[ram_addr_1] <= ram_din_1;
            if (ram_we_2) mem[ram_addr_2] <= ram_din_2;
            ram_dout_2 <= mem[ram_addr_2];
        end
    end

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: contents as a queue, sticky flags as bits.
    logic [W-1:0] model_q[$];
    bit           m_ovf, m_udf;

    task automatic check_state(input string tag);
        int n;
        n = model_q.size();
        chk({tag, ".count"}, count, n);
        chk({tag, ".full"}, full, n == D);
        chk({tag, ".empty"}, empty, n == 0);
        chk({tag, ".almost_full"}, almost_full, n >= D - 4);
        chk({tag, ".almost_empty"}, almost_empty, n <= 4);
        chk({tag, ".overflow"}, overflow, m_ovf);
        chk({tag, ".underflow"}, underflow, m_udf);
    endtask

    task automatic step(input logic w, input logic r, input logic [W-1:0] d);
        bit pop_ok, push_ok;
        logic [W-1:0] exp_d;
        pop_ok  = r && (model_q.size() != 0);
        push_ok = w && (model_q.size() < D || pop_ok);
        exp_d   = '0;
        if (pop_ok)  exp_d = model_q.pop_front();
        if (push_ok) model_q.push_back(d);
        if (w && !push_ok) m_ovf = 1'b1;
        if (r && !pop_ok)  m_udf = 1'b1;
        wr_en = w; rd_en = r; wr_data = d;
        #1;
        chk("ram_we_1", ram_we_1, push_ok);
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
        check_state("step");
        chk("rd_valid", rd_valid, pop_ok);
        if (pop_ok) chk("rd_data", rd_data, exp_d);
    endtask

    task automatic do_reset(input logic w, input logic r);
        rst = 1'b1; wr_en = w; rd_en = r; wr_data = 8'hEE;
        #1;
        chk("ram_rst_n_in_rst", ram_rst_n, 1'b0);
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
        model_q.delete();
        m_ovf = 1'b0; m_udf = 1'b0;
        check_state("reset");
        chk("reset.rd_valid", rd_valid, 1'b0);
        rst = 1'b0;
        #1;
        chk("ram_rst_n_after", ram_rst_n, 1'b1);
    endtask

    typedef struct {
        logic         w, r;
        logic [W-1:0] d;
        int           cnt;
        logic         emp, rdv;
        logic [W-1:0] rdat;
        logic         udf;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [W-1:0] rd;
        vecs[0] = '{1'b1, 1'b0, 8'h11, 1, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 8'h22, 2, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b1, 8'h11, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 8'h33, 1, 1'b0, 1'b1, 8'h22, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b1, 8'h33, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 8'h00, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 8'h44, 1, 1'b0, 1'b0, 8'h00, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b1, 8'h44, 1'b1};

        // Reset then idle
        do_reset(1'b0, 1'b0);
        do_reset(1'b0, 1'b0);
        chk("ram_we_2", ram_we_2, 1'b0);
        chk("ram_din_2", ram_din_2, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        // Table vectors straight out of reset
        foreach (vecs[i]) begin
            wr_en = vecs[i].w; rd_en = vecs[i].r; wr_data = vecs[i].d;
            @(posedge clk); #1;
            wr_en = 1'b0; rd_en = 1'b0;
            chk($sformatf("vec%0d.count", i), count, vecs[i].cnt);
            chk($sformatf("vec%0d.empty", i), empty, vecs[i].emp);
            chk($sformatf("vec%0d.rd_valid", i), rd_valid, vecs[i].rdv);
            chk($sformatf("vec%0d.underflow", i), underflow, vecs[i].udf);
            if (vecs[i].rdv) chk($sformatf("vec%0d.rd_data", i), rd_data, vecs[i].rdat);
        end

        // Fill 0x01..0x40 then drain in order
        do_reset(1'b0, 1'b0);
        for (int i = 1; i <= D; i++) step(1'b1, 1'b0, W'(i));
        chk("fill.full", full, 1'b1);
        for (int i = 0; i < D; i++) step(1'b0, 1'b1, 8'h00);
        chk("drain.empty", empty, 1'b1);

        // Overflow: 0xAA must be dropped
        for (int i = 0; i < D; i++) step(1'b1, 1'b0, W'($urandom_range(0, 8'hA9)));
        step(1'b1, 1'b0, 8'hAA);
        chk("ovf.flag", overflow, 1'b1);
        chk("ovf.count", count, 7'd64);
        for (int i = 0; i < D; i++) step(1'b0, 1'b1, 8'h00);

        // Pop on empty with simultaneous push
        do_reset(1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h5C);
        chk("udf.flag", underflow, 1'b1);
        chk("udf.count", count, 7'd1);
        step(1'b0, 1'b1, 8'h00);
        chk("udf.rd_data", rd_data, 8'h5C);

        // Push and pop while full
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < D; i++) step(1'b1, 1'b0, W'(i + 8'h80));
        step(1'b1, 1'b1, 8'h77);
        chk("fullpp.rd_data", rd_data, 8'h80);
        chk("fullpp.count", count, 7'd64);
        for (int i = 0; i < D; i++) begin
            step(1'b0, 1'b1, 8'h00);
            rd = rd_data;
        end
        chk("fullpp.last", rd, 8'h77);

        // Random traffic across the pointer wrap, reset at cycle 150
        do_reset(1'b0, 1'b0);
        for (int c = 0; c < 200; c++) begin
            if (c == 150) begin
                do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                chk("rnd.rst_count", count, 7'd0);
                chk("rnd.rst_empty", empty, 1'b1);
            end else begin
                step(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 5),
                     W'($urandom));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
Synchronous FIFO controller that sits directly upstream of the 64x8 dual-port RAM and uses it as storage.
- Owns the write/read pointers, occupancy and status flags.
- Drives RAM port 1 as the write port and RAM port 2 as the read port, both on one clock.
- Takes the RAM's registered port-2 read data and presents it to the consumer with a valid strobe.

Parameters:
WIDTH, 8, data word width; must match the RAM WIDTH.
DEPTH, 64, number of entries; power of two, must match the RAM DEPTH.
ADDR_BUS, $clog2(DEPTH), RAM address width (6 at default).
AF_LEVEL, DEPTH-4, count at or above which almost_full asserts.
AE_LEVEL, 4, count at or below which almost_empty asserts.

Ports:
clk  in  1  single clock; the RAM's clk_1 and clk_2 both tie to it.
rst  in  1  synchronous, active-high reset.
wr_en  in  1  push request.
wr_data  in  WIDTH  push data.
rd_en  in  1  pop request.
rd_data  out  WIDTH  popped word; valid when rd_valid=1.
rd_valid  out  1  high exactly one cycle after an accepted pop.
full / empty  out  1  status flags, registered.
almost_full / almost_empty  out  1  threshold flags, registered.
count  out  ADDR_BUS+1  occupancy, 0..DEPTH.
overflow / underflow  out  1  sticky error flags; cleared only by rst.
ram_rst_n  out  1  drives RAM rst_1 and rst_2 (active-low there).
ram_we_1  out  1  drives RAM we_1.
ram_addr_1  out  ADDR_BUS  drives RAM addr_1.
ram_din_1  out  WIDTH  drives RAM din_1.
ram_we_2  out  1  drives RAM we_2; tied 0.
ram_addr_2  out  ADDR_BUS  drives RAM addr_2.
ram_din_2  out  WIDTH  drives RAM din_2; tied 0.
ram_dout_2  in  WIDTH  RAM dout_2; updates one clock after a read address is sampled.

Behaviour:
Reset (rst=1 at posedge):
- wr_ptr = rd_ptr = 0, count = 0, empty = 1, almost_empty = 1.
- full, almost_full, rd_valid, overflow and underflow = 0.
- ram_rst_n = ~rst, combinational, so the RAM clears in the same cycles.
- Reset mid-operation discards all contents and any pending rd_valid.
- The first push or pop is accepted on the first cycle after rst deasserts.

Pointers:
- wr_ptr and rd_ptr are ADDR_BUS+1 bits; the MSB is a wrap bit.
- empty when pointers are equal; full when low bits are equal and the MSBs differ.
- ram_addr_1 = wr_ptr[ADDR_BUS-1:0]; ram_addr_2 = rd_ptr[ADDR_BUS-1:0].

Accept rules, evaluated on the current registered flags:
- pop_ok = rd_en & ~empty.
- push_ok = wr_en & (~full | pop_ok).

Write path:
- ram_we_1 = push_ok and ram_din_1 = wr_data, both combinational; the RAM captures them at the same posedge.
- wr_ptr increments on push_ok.

Read path:
- ram_we_2 = 0 permanently, so the RAM's port 2 performs a read every cycle.
- rd_ptr increments on pop_ok.
- rd_valid <= pop_ok.
- rd_data = ram_dout_2 (combinational pass-through), qualified by rd_valid.
- Read latency: pop at edge N gives rd_valid=1 and correct data in the cycle after edge N, one cycle total.

Count:
- count <= count + push_ok - pop_ok.
- Flags are registered from the next-state count: full = (next == DEPTH), empty = (next == 0), almost_full = (next >= AF_LEVEL), almost_empty = (next <= AE_LEVEL).

Boundary cases:
- Push while full without pop: dropped, overflow <= 1, no state change.
- Pop while empty: rejected, underflow <= 1, rd_valid stays 0. A simultaneous push is still accepted.
- Push and pop while full: both accepted, count holds at DEPTH. Same address on both ports; the RAM returns old data (read before write), which is the correct FIFO word.
- Push and pop at count 1: both accepted, count stays 1, no write/read hazard (different addresses).
- Pointer wrap from DEPTH-1 to 0 toggles the MSB; no special handling is needed.

Decomposition:
- Shared package fifo_pkg: WIDTH/DEPTH defaults, the ADDR_BUS derivation, the pointer typedef (ADDR_BUS+1 bits) and the threshold defaults.
- No sub-module inside the controller.
- Verification and integration use a wrapper ram_fifo that instantiates ram_fifo_ctrl plus dual_port_RAM.

Test Plan:
1. Reset then idle -> empty=1, almost_empty=1, count=0, rd_valid=0, all other flags 0; ram_rst_n=0 during rst.
2. Push 0x01..0x40 (64 words) -> full=1 after the 64th, almost_full from count 60. Pop 64 -> rd_data 0x01..0x40 in order, each one cycle after its pop, empty=1 at end.
3. Fill to 64, push 0xAA without pop -> overflow=1, count stays 64. Pop 64 -> 0xAA never appears.
4. Empty, assert rd_en and wr_en=1 with wr_data=0x5C together -> underflow=1, rd_valid=0, count=1. Next pop returns 0x5C.
5. Full, simultaneous push 0x77 and pop -> rd_data is the oldest word and count stays 64. Drain -> 0x77 is last out.
6. 200 cycles of random push/pop crossing the wrap, with rst asserted at cycle 150 -> scoreboard matches before reset; count=0, empty=1, sticky flags cleared after reset.
